// File: rtl/coin_payout_pkg.sv
// Shared types and widths for the coin payout block.
// The JAM state exists only when COIN_PAYOUT_TIMEOUT_EN is defined.
package coin_payout_pkg;

    localparam int CNT_W = 3;
    localparam int LVL_W = 8;
    localparam logic [LVL_W-1:0] LVL_MAX = 8'd255;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RELEASE = 3'd1,
        S_PAY     = 3'd2,
        S_WAIT    = 3'd3,
        S_GAP     = 3'd4,
        S_DONE    = 3'd5
`ifdef COIN_PAYOUT_TIMEOUT_EN
        ,
        S_JAM     = 3'd6
`endif
    } state_t;

    // Refill and coin ejection may land in the same cycle; apply both, then saturate.
    function automatic logic [LVL_W-1:0] level_next(input logic [LVL_W-1:0] cur,
                                                    input logic [LVL_W-1:0] add,
                                                    input logic             dec);
        logic [LVL_W+1:0] sum;
        sum = {2'b00, cur} + {2'b00, add} - {{(LVL_W+1){1'b0}}, dec};
        if (sum > {2'b00, LVL_MAX})
            level_next = LVL_MAX;
        else
            level_next = sum[LVL_W-1:0];
    endfunction

endpackage

// File: rtl/coin_payout_if.sv
// Vend-side and hopper-side signals of the coin payout block.
interface coin_payout_if;
    import coin_payout_pkg::*;

    logic             pdt;
    logic [CNT_W-1:0] cng;
    logic [CNT_W-1:0] rtn;
    logic             refill;
    logic [LVL_W-1:0] refill_cnt;
    logic             hop_ack;

    logic             item_rel;
    logic             hop_req;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] shortfall;
    logic [LVL_W-1:0] level;
    logic             empty;
    logic             jam;
    logic             overrun;

    modport master (
        output pdt, cng, rtn, refill, refill_cnt, hop_ack,
        input  item_rel, hop_req, busy, done, shortfall, level, empty, jam, overrun
    );

    modport slave (
        input  pdt, cng, rtn, refill, refill_cnt, hop_ack,
        output item_rel, hop_req, busy, done, shortfall, level, empty, jam, overrun
    );

endinterface

// File: rtl/coin_payout_edge.sv
// Registered-history rising-edge detector for the vend strobe and the refund-nonzero condition.
module coin_payout_edge (
    input  logic clk,
    input  logic rst,
    input  logic pdt,
    input  logic rtn_nz,
    output logic pdt_rise,
    output logic rtn_rise
);

    logic pdt_q;
    logic rtn_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pdt_q <= 1'b0;
            rtn_q <= 1'b0;
        end else begin
            pdt_q <= pdt;
            rtn_q <= rtn_nz;
        end
    end

    assign pdt_rise = pdt & ~pdt_q;
    assign rtn_rise = rtn_nz & ~rtn_q;

endmodule

// File: rtl/coin_payout.sv
// Coin payout controller: pays change or refunds one coin at a time from the hopper.
// Define COIN_PAYOUT_TIMEOUT_EN to enable the hopper-ack timeout and the sticky JAM state.
module coin_payout
    import coin_payout_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int HOPPER_INIT = 32
) (
    input  logic clk,
    input  logic rst,
    coin_payout_if.slave bus
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] amt;
    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] shortfall;
    logic             overrun;
    logic             pdt_rise;
    logic             rtn_rise;
    logic             load_pdt;
    logic             load_rtn;
    logic             dec;
    logic             set_short;

    coin_payout_edge u_edge (
        .clk      (clk),
        .rst      (rst),
        .pdt      (bus.pdt),
        .rtn_nz   (bus.rtn != '0),
        .pdt_rise (pdt_rise),
        .rtn_rise (rtn_rise)
    );

`ifdef COIN_PAYOUT_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0] tmr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tmr <= '0;
        else if (state == S_WAIT)
            tmr <= tmr + TMR_W'(1);
        else
            tmr <= '0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_pdt   = 1'b0;
        load_rtn   = 1'b0;
        dec        = 1'b0;
        set_short  = 1'b0;
        case (state)
            S_IDLE: begin
                // A simultaneous refund edge loses to the sale and is simply dropped.
                if (pdt_rise) begin
                    load_pdt   = 1'b1;
                    state_next = S_RELEASE;
                end else if (rtn_rise) begin
                    load_rtn   = 1'b1;
                    state_next = S_PAY;
                end
            end
            S_RELEASE: state_next = S_PAY;
            S_PAY: begin
                if (amt == '0) begin
                    state_next = S_DONE;
                end else if (level == '0) begin
                    set_short  = 1'b1;
                    state_next = S_DONE;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.hop_ack) begin
                    dec        = 1'b1;
                    state_next = S_GAP;
                end
`ifdef COIN_PAYOUT_TIMEOUT_EN
                else if (tmr == TMR_W'(TIMEOUT_CYC - 1)) begin
                    set_short  = 1'b1;
                    state_next = S_JAM;
                end
`endif
            end
            S_GAP:  state_next = S_PAY;
            S_DONE: state_next = S_IDLE;
`ifdef COIN_PAYOUT_TIMEOUT_EN
            S_JAM:  state_next = S_JAM;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            amt       <= '0;
            level     <= LVL_W'(HOPPER_INIT);
            shortfall <= '0;
            overrun   <= 1'b0;
        end else begin
            level <= level_next(level, bus.refill ? bus.refill_cnt : '0, dec);
            if (load_pdt)
                amt <= bus.cng;
            else if (load_rtn)
                amt <= bus.rtn;
            else if (dec)
                amt <= amt - CNT_W'(1);
            if (load_pdt || load_rtn)
                shortfall <= '0;
            else if (set_short)
                shortfall <= amt;
            if ((state != S_IDLE) && (pdt_rise || rtn_rise))
                overrun <= 1'b1;
        end
    end

    assign bus.item_rel  = (state == S_RELEASE);
    assign bus.hop_req   = (state == S_WAIT);
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.shortfall = shortfall;
    assign bus.level     = level;
    assign bus.empty     = (level == '0);
    assign bus.overrun   = overrun;
`ifdef COIN_PAYOUT_TIMEOUT_EN
    assign bus.jam       = (state == S_JAM);
`else
    assign bus.jam       = 1'b0;
`endif

endmodule

// File: tb/tb_coin_payout.sv
// Directed self-checking bench for coin_payout; the jam scenario runs when COIN_PAYOUT_TIMEOUT_EN is defined.
module tb_coin_payout;
    import coin_payout_pkg::*;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    bit   ack_en = 1'b0;
    int   rel_cnt = 0;
    int   done_cnt = 0;
    int   ack_cnt = 0;

    coin_payout_if bus ();

    coin_payout #(
        .TIMEOUT_CYC (16),
        .HOPPER_INIT (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hopper model: acknowledges one cycle after each request and tallies strobes.
    always @(posedge clk) begin
        #1;
        if (bus.item_rel) rel_cnt++;
        if (bus.done) done_cnt++;
        bus.hop_ack = ack_en && bus.hop_req;
        if (bus.hop_ack) ack_cnt++;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic pdt, input logic [2:0] cng, input logic [2:0] rtn);
        bus.pdt = pdt;
        bus.cng = cng;
        bus.rtn = rtn;
    endtask

    task automatic waitDone(input int max, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!bus.done && cycles < max);
        if (!bus.done) cycles = -1;
    endtask

    task automatic cancel(input logic [2:0] n, input string tag);
        int cyc;
        applyStimulus(1'b0, 3'd0, n);
        waitDone(100, cyc);
        checkOutput(tag, cyc, 3 * int'(n) + 2);
        applyStimulus(1'b0, 3'd0, 3'd0);
        step();
    endtask

    initial begin
        int cyc;
        int r0, a0;
        rst = 1'b0;
        applyStimulus(1'b0, 3'd0, 3'd0);
        bus.refill = 1'b0;
        bus.refill_cnt = 8'd0;
        bus.hop_ack = 1'b0;
        step();
        step();
        checkOutput("rst_level", int'(bus.level), 32);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_hop_req", int'(bus.hop_req), 0);
        checkOutput("rst_flags", int'({bus.item_rel, bus.done, bus.jam, bus.overrun, bus.empty}), 0);
        checkOutput("rst_shortfall", int'(bus.shortfall), 0);
        rst = 1'b1;
        ack_en = 1'b1;
        step();

        // Sale of 2: RELEASE, then PAY entry, then 3N+1 cycles to done.
        r0 = rel_cnt; a0 = ack_cnt;
        applyStimulus(1'b1, 3'd2, 3'd0);
        step();
        checkOutput("sale_item_rel", int'(bus.item_rel), 1);
        waitDone(100, cyc);
        checkOutput("sale_latency", cyc, 8);
        checkOutput("sale_level", int'(bus.level), 30);
        checkOutput("sale_rel_count", rel_cnt - r0, 1);
        checkOutput("sale_acks", ack_cnt - a0, 2);
        checkOutput("sale_shortfall", int'(bus.shortfall), 0);
        applyStimulus(1'b0, 3'd0, 3'd0);
        step();
        checkOutput("sale_done_one_cycle", int'(bus.done), 0);
        checkOutput("sale_idle", int'(bus.busy), 0);

        // Cancel of 4: no item release.
        r0 = rel_cnt; a0 = ack_cnt;
        cancel(3'd4, "cancel_latency");
        checkOutput("cancel_level", int'(bus.level), 26);
        checkOutput("cancel_no_rel", rel_cnt - r0, 0);
        checkOutput("cancel_acks", ack_cnt - a0, 4);

        // Simultaneous pdt and rtn edges: sale wins, no overrun.
        r0 = rel_cnt;
        applyStimulus(1'b1, 3'd1, 3'd2);
        waitDone(100, cyc);
        checkOutput("both_latency", cyc, 6);
        checkOutput("both_level", int'(bus.level), 25);
        checkOutput("both_rel", rel_cnt - r0, 1);
        checkOutput("both_no_overrun", int'(bus.overrun), 0);
        applyStimulus(1'b0, 3'd0, 3'd0);
        step();

        // Second pdt edge while busy: overrun, payout unaffected.
        a0 = ack_cnt;
        applyStimulus(1'b1, 3'd2, 3'd0);
        step();
        bus.pdt = 1'b0;
        step();
        bus.pdt = 1'b1;
        step();
        checkOutput("ovr_flag", int'(bus.overrun), 1);
        waitDone(100, cyc);
        checkOutput("ovr_latency", cyc + 3, 9);
        checkOutput("ovr_level", int'(bus.level), 23);
        checkOutput("ovr_acks", ack_cnt - a0, 2);
        applyStimulus(1'b0, 3'd0, 3'd0);
        step();
        checkOutput("ovr_sticky", int'(bus.overrun), 1);

        // Drain to a single coin, then a sale of 3 falls short by 2.
        cancel(3'd7, "drain_a");
        cancel(3'd7, "drain_b");
        cancel(3'd7, "drain_c");
        cancel(3'd1, "drain_d");
        checkOutput("drain_level", int'(bus.level), 1);
        a0 = ack_cnt;
        applyStimulus(1'b1, 3'd3, 3'd0);
        waitDone(100, cyc);
        checkOutput("short_latency", cyc, 6);
        checkOutput("short_acks", ack_cnt - a0, 1);
        checkOutput("short_shortfall", int'(bus.shortfall), 2);
        checkOutput("short_empty", int'(bus.empty), 1);
        applyStimulus(1'b0, 3'd0, 3'd0);
        step();
        checkOutput("short_hold", int'(bus.shortfall), 2);

        // Refill, saturation, and refill coinciding with a coin ejection.
        bus.refill = 1'b1;
        bus.refill_cnt = 8'd30;
        step();
        bus.refill = 1'b0;
        checkOutput("refill_30", int'(bus.level), 30);
        checkOutput("refill_not_empty", int'(bus.empty), 0);
        bus.refill = 1'b1;
        bus.refill_cnt = 8'd250;
        step();
        bus.refill = 1'b0;
        checkOutput("refill_sat", int'(bus.level), 255);
        applyStimulus(1'b0, 3'd0, 3'd1);
        step();
        step();
        checkOutput("net_hop_req", int'(bus.hop_req), 1);
        checkOutput("net_shortfall_cleared", int'(bus.shortfall), 0);
        bus.refill = 1'b1;
        bus.refill_cnt = 8'd3;
        step();
        bus.refill = 1'b0;
        checkOutput("net_refill_dec", int'(bus.level), 255);
        waitDone(100, cyc);
        checkOutput("net_done", cyc > 0 ? 1 : 0, 1);
        applyStimulus(1'b0, 3'd0, 3'd0);
        step();

        // Reset while waiting for the hopper.
        ack_en = 1'b0;
        applyStimulus(1'b0, 3'd0, 3'd2);
        step();
        step();
        checkOutput("rw_hop_req_before", int'(bus.hop_req), 1);
        rst = 1'b0;
        #1;
        checkOutput("rw_hop_req_drop", int'(bus.hop_req), 0);
        checkOutput("rw_level", int'(bus.level), 32);
        checkOutput("rw_shortfall", int'(bus.shortfall), 0);
        applyStimulus(1'b0, 3'd0, 3'd0);
        step();
        rst = 1'b1;
        step();

        // Withheld acknowledge.
        applyStimulus(1'b1, 3'd1, 3'd0);
        step();
        step();
        step();
        checkOutput("to_hop_req", int'(bus.hop_req), 1);
        repeat (15) step();
        checkOutput("to_no_jam_yet", int'(bus.jam), 0);
        step();
`ifdef COIN_PAYOUT_TIMEOUT_EN
        checkOutput("to_jam", int'(bus.jam), 1);
        checkOutput("to_hop_req_low", int'(bus.hop_req), 0);
        checkOutput("to_shortfall", int'(bus.shortfall), 1);
        repeat (4) step();
        checkOutput("to_jam_sticky", int'(bus.jam), 1);
`else
        repeat (4) step();
        checkOutput("to_still_waiting", int'(bus.hop_req), 1);
        checkOutput("to_jam_tied", int'(bus.jam), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/coin_payout.md
COIN_PAYOUT -- requirements
Module: coin_payout

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: cycles allowed between hop_req assertion and hop_ack before a jam is declared.
REQ-002 Parameter HOPPER_INIT, default 32: 1-unit coins held in the hopper after reset.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 pdt  input  1  vend indication from the vending FSM; the rising edge means a sale has completed.
REQ-006 cng  input  3  change owed in 1-unit coins; valid while pdt=1.
REQ-007 rtn  input  3  refund in 1-unit coins; a transition from zero to non-zero means a cancel.
REQ-008 refill  input  1  one-cycle pulse that adds refill_cnt coins to the hopper level.
REQ-009 refill_cnt  input  8  number of coins added on refill.
REQ-010 hop_ack  input  1  hopper sensor pulse, one cycle per coin ejected.
REQ-011 item_rel  output  1  one-cycle item-release strobe.
REQ-012 hop_req  output  1  hopper motor request; held high until hop_ack.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle strobe at the end of a payout.
REQ-015 shortfall  output  3  coins owed but not paid on the last payout.
REQ-016 level  output  8  current hopper coin count.
REQ-017 empty  output  1  high when level==0.
REQ-018 jam  output  1  sticky jam flag.
REQ-019 overrun  output  1  sticky flag: an event arrived while busy.

Function
REQ-020 pdt and rtn pass through a one-cycle registered edge detector; an event is accepted only in IDLE.
REQ-021 Accepting a pdt rising edge latches amt=cng, pulses item_rel in the next cycle (state RELEASE), then moves to PAY.
REQ-022 Accepting an rtn rising edge latches amt=rtn and moves directly to PAY; item_rel stays 0.
REQ-023 If pdt and rtn edges occur in the same cycle, pdt wins and the rtn event is discarded without setting overrun.
REQ-024 An edge that arrives outside IDLE is dropped and sets overrun; only reset clears overrun.
REQ-025 PAY behaviour:
  - amt==0 -> DONE.
  - level==0 -> shortfall=amt, then DONE.
  - otherwise assert hop_req and go to WAIT.
REQ-026 In WAIT, hop_ack causes: hop_req low, amt-1, level-1, then GAP for exactly one cycle, then PAY.
REQ-027 hop_ack outside WAIT is ignored and changes nothing.
REQ-028 DONE pulses done for one cycle, then returns to IDLE; shortfall holds until the next accepted event, which clears it to 0.
REQ-029 Payout latency for amt=N with ack one cycle after each hop_req: 3N+1 cycles from PAY entry to the done pulse.
REQ-030 refill adds refill_cnt to level in any state, saturating at 255.
REQ-031 If refill and a coin decrement occur in the same cycle, the net result is level+refill_cnt-1, saturated.
REQ-032 States: IDLE, RELEASE, PAY, WAIT, GAP, DONE, JAM, 3-bit encoding.

Reset
REQ-033 While rst=0, the block is forced into IDLE with:
  - outputs: hop_req, item_rel, done, busy, jam, overrun at 0; shortfall=0; level=HOPPER_INIT.
  - internal: amt=0, edge-detector history=0.
REQ-034 Reset during WAIT drops hop_req immediately (asynchronously) and abandons the pending payout, with no shortfall recorded.

Configuration
REQ-035 With COIN_PAYOUT_TIMEOUT_EN defined:
  - a counter runs in WAIT; reaching TIMEOUT_CYC without hop_ack moves to JAM.
  - in JAM: hop_req=0, jam=1, shortfall=amt; JAM is left only by reset.
REQ-036 Without COIN_PAYOUT_TIMEOUT_EN, WAIT waits indefinitely, jam is tied to 0, and the JAM state and counter are absent.

Structure
REQ-037 Package coin_payout_pkg holds:
  - the state enum typedef;
  - the coin-count width (3) and level width (8) constants.
REQ-038 A sub-module coin_payout_edge shall implement the registered edge detector for pdt and for rtn!=0.

Verification
REQ-039 Sale with pdt rise, cng=2, level=32, ack one cycle after each req:
  - item_rel pulses once; two hop_req/ack pairs occur.
  - done pulses; level=30; shortfall=0.
REQ-040 Cancel with rtn 0->4, level=32: four coins paid, item_rel stays 0, level=28, done pulses.
REQ-041 Shortfall case, level=1, pdt with cng=3: one coin paid, then shortfall=2, empty=1, done pulses.
REQ-042 Timeout case (macro on, TIMEOUT_CYC=16), pdt with cng=1 and hop_ack withheld: jam=1 sixteen cycles after hop_req, hop_req=0, shortfall=1.
REQ-043 Overrun and refill:
  - a second pdt edge while busy sets overrun=1 and leaves the current payout unaffected;
  - refill_cnt=250 at level=30 gives level=255.
REQ-044 Reset mid-WAIT: rst low drops hop_req in the same time step; level returns to 32.
